// File: rtl/cpu_types_pkg.sv
// Shared MIPS decode types: opcodes, functs, ALU ops, packed control word and jump classes.
package cpu_types_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_ADDIU = 6'h09,
    OP_SLTI  = 6'h0A,
    OP_SLTIU = 6'h0B,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_XORI  = 6'h0E,
    OP_LUI   = 6'h0F,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B,
    OP_HALT  = 6'h3F
  } opcode_t;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00,
    FN_JR   = 6'h08,
    FN_ADD  = 6'h20,
    FN_ADDU = 6'h21,
    FN_SUB  = 6'h22,
    FN_SUBU = 6'h23,
    FN_AND  = 6'h24,
    FN_OR   = 6'h25,
    FN_XOR  = 6'h26,
    FN_SLT  = 6'h2A
  } funct_t;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_RTYPE = 4'd7
  } aluop_t;

  typedef enum logic [1:0] {
    JMP_NONE = 2'd0,
    JMP_J    = 2'd1,
    JMP_JR   = 2'd2
  } jump_t;

  typedef struct packed {
    logic   regwrite;
    logic   memread;
    logic   memwrite;
    logic   alusrc;
    logic   regdst;
    aluop_t aluop;
    logic   branch_eq;
    logic   branch_ne;
    logic   link;
    logic   lui;
  } ctrl_t;

  localparam logic [5:0] HALT_OPCODE = 6'b111111;
  localparam logic [5:0] JR_FUNCT    = 6'b001000;

endpackage

// File: rtl/control_decoder.sv
// Combinational opcode/funct decode into the control word, register-use flags and jump class.
module control_decoder
  import cpu_types_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl,
  output logic       uses_rs,
  output logic       uses_rt,
  output jump_t      jump_class
);

  always_comb begin
    ctrl       = '0;
    uses_rs    = 1'b1;
    uses_rt    = 1'b0;
    jump_class = JMP_NONE;
    case (opcode_t'(opcode))
      OP_RTYPE: begin
        uses_rt = 1'b1;
        if (funct == JR_FUNCT) begin
          jump_class = JMP_JR;
        end else begin
          ctrl.regwrite = 1'b1;
          ctrl.regdst   = 1'b1;
          ctrl.aluop    = ALU_RTYPE;
        end
      end
      OP_J: begin
        uses_rs    = 1'b0;
        jump_class = JMP_J;
      end
      OP_JAL: begin
        uses_rs       = 1'b0;
        jump_class    = JMP_J;
        ctrl.regwrite = 1'b1;
        ctrl.link     = 1'b1;
      end
      OP_BEQ: begin
        uses_rt        = 1'b1;
        ctrl.branch_eq = 1'b1;
        ctrl.aluop     = ALU_SUB;
      end
      OP_BNE: begin
        uses_rt        = 1'b1;
        ctrl.branch_ne = 1'b1;
        ctrl.aluop     = ALU_SUB;
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluop    = ALU_ADD;
      end
      OP_SLTI:  begin ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.aluop = ALU_SLT;  end
      OP_SLTIU: begin ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.aluop = ALU_SLTU; end
      OP_ANDI:  begin ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.aluop = ALU_AND;  end
      OP_ORI:   begin ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.aluop = ALU_OR;   end
      OP_XORI:  begin ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.aluop = ALU_XOR;  end
      OP_LUI: begin
        uses_rs       = 1'b0;
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.lui      = 1'b1;
      end
      OP_LW: begin
        ctrl.regwrite = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.alusrc   = 1'b1;
      end
      OP_SW: begin
        uses_rt       = 1'b1;
        ctrl.memwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
      end
      OP_HALT: uses_rs = 1'b0;
      // Unknown opcodes decode to an all-zero control word and behave as NOPs.
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/fetch_decode_stage.sv
// IF/ID pipeline register with decode, load-use detection, jump resolution and sticky halt.
// Decode is combinational from the latched instruction; stall/flush/halt freeze or squash the latch.
module fetch_decode_stage
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT   = 32'h0,
  parameter logic [31:0] NOP_INSTR = 32'h0,
  parameter logic [5:0]  HALT_OP   = 6'b111111
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_pp4,
  input  logic        if_valid,
  input  logic        mem_stall,
  input  logic        flush,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rt,
  input  logic [31:0] rf_rdat1,
  input  logic [31:0] rf_rdat2,
  output logic [4:0]  rf_rsel1,
  output logic [4:0]  rf_rsel2,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pp4,
  output logic [5:0]  id_opcode,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_rd,
  output logic [4:0]  id_shamt,
  output logic [5:0]  id_funct,
  output logic [31:0] id_imm_ext,
  output logic [31:0] id_rdat1,
  output logic [31:0] id_rdat2,
  output ctrl_t       id_ctrl,
  output logic        load_use,
  output logic [1:0]  jump_sig,
  output logic [31:0] jump_add,
  output logic [31:0] jump_jr,
  output logic        halt
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pp4_q, pp4_d;
  logic        valid_q, valid_d;
  logic        halt_q, halt_d;

  ctrl_t dec_ctrl;
  logic  uses_rs, uses_rt;
  jump_t jump_class;
  logic  zero_ext;

  control_decoder u_control_decoder (
    .opcode     (instr_q[31:26]),
    .funct      (instr_q[5:0]),
    .ctrl       (dec_ctrl),
    .uses_rs    (uses_rs),
    .uses_rt    (uses_rt),
    .jump_class (jump_class)
  );

  always_comb begin
    id_opcode  = instr_q[31:26];
    id_rs      = instr_q[25:21];
    id_rt      = instr_q[20:16];
    id_rd      = instr_q[15:11];
    id_shamt   = instr_q[10:6];
    id_funct   = instr_q[5:0];
    rf_rsel1   = id_rs;
    rf_rsel2   = id_rt;
    id_rdat1   = rf_rdat1;
    id_rdat2   = rf_rdat2;
    id_valid   = valid_q;
    id_pc      = pc_q;
    id_pp4     = pp4_q;
    halt       = halt_q;
    zero_ext   = (id_opcode == OP_ANDI) || (id_opcode == OP_ORI) || (id_opcode == OP_XORI);
    id_imm_ext = zero_ext ? {16'h0, instr_q[15:0]} : {{16{instr_q[15]}}, instr_q[15:0]};

    load_use = valid_q && idex_memread && (idex_rt != 5'd0) &&
               (((idex_rt == id_rs) && uses_rs) || ((idex_rt == id_rt) && uses_rt));

    id_ctrl  = valid_q ? dec_ctrl : '0;
    // A JR must not redirect fetch until its rs value is out of the load shadow.
    jump_sig = (valid_q && !load_use) ? jump_class : JMP_NONE;
    jump_add = {pp4_q[31:28], instr_q[25:0], 2'b00};
    jump_jr  = rf_rdat1;
  end

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    pp4_d   = pp4_q;
    valid_d = valid_q;
    halt_d  = halt_q;
    if (halt_q || mem_stall) begin
      // frozen
    end else begin
      if (valid_q && (id_opcode == HALT_OP) && !flush) begin
        halt_d = 1'b1;
      end
      if (flush) begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end else if (load_use) begin
        // hold until ID/EX has inserted its bubble
      end else if (if_valid) begin
        instr_d = if_instr;
        pc_d    = if_pc;
        pp4_d   = if_pp4;
        valid_d = 1'b1;
      end else begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      instr_q <= NOP_INSTR;
      pc_q    <= PC_INIT;
      pp4_q   <= 32'h0;
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pp4_q   <= pp4_d;
      valid_q <= valid_d;
      halt_q  <= halt_d;
    end
  end

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage with hand-computed expectations checked by immediate assertions.
module tb_fetch_decode_stage;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] if_instr, if_pc, if_pp4;
  logic        if_valid, mem_stall, flush, idex_memread;
  logic [4:0]  idex_rt;
  logic [31:0] rf_rdat1, rf_rdat2;
  logic [4:0]  rf_rsel1, rf_rsel2;
  logic        id_valid;
  logic [31:0] id_pc, id_pp4;
  logic [5:0]  id_opcode, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [31:0] id_imm_ext, id_rdat1, id_rdat2;
  ctrl_t       id_ctrl;
  logic        load_use;
  logic [1:0]  jump_sig;
  logic [31:0] jump_add, jump_jr;
  logic        halt;

  int total = 0;
  int bad   = 0;

  fetch_decode_stage dut (
    .CLK(CLK), .RST(RST), .if_instr(if_instr), .if_pc(if_pc), .if_pp4(if_pp4),
    .if_valid(if_valid), .mem_stall(mem_stall), .flush(flush),
    .idex_memread(idex_memread), .idex_rt(idex_rt),
    .rf_rdat1(rf_rdat1), .rf_rdat2(rf_rdat2), .rf_rsel1(rf_rsel1), .rf_rsel2(rf_rsel2),
    .id_valid(id_valid), .id_pc(id_pc), .id_pp4(id_pp4), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt), .id_funct(id_funct),
    .id_imm_ext(id_imm_ext), .id_rdat1(id_rdat1), .id_rdat2(id_rdat2), .id_ctrl(id_ctrl),
    .load_use(load_use), .jump_sig(jump_sig), .jump_add(jump_add), .jump_jr(jump_jr),
    .halt(halt)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] pp4);
    if_instr = instr;
    if_pc    = pc;
    if_pp4   = pp4;
    if_valid = 1'b1;
    tick();
  endtask

  initial begin
    RST = 1'b1; if_instr = '0; if_pc = '0; if_pp4 = '0; if_valid = 1'b0;
    mem_stall = 1'b0; flush = 1'b0; idex_memread = 1'b0; idex_rt = '0;
    rf_rdat1 = '0; rf_rdat2 = '0;
    tick(); tick();
    RST = 1'b0;
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_pc",    id_pc, 32'h0);
    chk("rst_halt",  32'(halt), 32'd0);
    chk("rst_ctrl",  32'(id_ctrl), 32'd0);
    chk("rst_jump",  32'(jump_sig), 32'd0);

    // addi $t0,$0,10
    fetch(32'h2008000A, 32'h40, 32'h44);
    chk("addi_valid",  32'(id_valid), 32'd1);
    chk("addi_pc",     id_pc, 32'h40);
    chk("addi_rt",     32'(id_rt), 32'd8);
    chk("addi_rsel2",  32'(rf_rsel2), 32'd8);
    chk("addi_imm",    id_imm_ext, 32'h0000000A);
    chk("addi_alusrc", 32'(id_ctrl.alusrc), 32'd1);
    chk("addi_regwr",  32'(id_ctrl.regwrite), 32'd1);

    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("midrst_valid", 32'(id_valid), 32'd0);
    chk("midrst_pc",    id_pc, 32'h0);
    chk("midrst_pp4",   id_pp4, 32'h0);
    chk("midrst_rt",    32'(id_rt), 32'd0);
    chk("midrst_ctrl",  32'(id_ctrl), 32'd0);

    // add $t1,$t0,$t0 behind a load to $t0
    fetch(32'h01084820, 32'h80, 32'h84);
    chk("add_regdst", 32'(id_ctrl.regdst), 32'd1);
    chk("add_rd",     32'(id_rd), 32'd9);
    idex_memread = 1'b1; idex_rt = 5'd8;
    if_instr = 32'h2008000A; if_pc = 32'hC0; if_pp4 = 32'hC4;
    #1;
    chk("lu_set", 32'(load_use), 32'd1);
    tick();
    idex_memread = 1'b0;
    #1;
    chk("lu_hold_pc", id_pc, 32'h80);
    chk("lu_drop",    32'(load_use), 32'd0);
    idex_memread = 1'b1; idex_rt = 5'd0;
    #1;
    chk("lu_rt0", 32'(load_use), 32'd0);
    idex_memread = 1'b0;

    // j 0x40
    fetch(32'h08000010, 32'h100, 32'h104);
    chk("j_sig", 32'(jump_sig), 32'd1);
    chk("j_add", jump_add, 32'h00000040);
    // jal 0x40 from the 0x1xxxxxxx region keeps the upper PC nibble
    fetch(32'h0C000010, 32'h10000004, 32'h10000008);
    chk("jal_sig",  32'(jump_sig), 32'd1);
    chk("jal_add",  jump_add, 32'h10000040);
    chk("jal_link", 32'(id_ctrl.link), 32'd1);
    chk("jal_rw",   32'(id_ctrl.regwrite), 32'd1);
    // jr $31
    rf_rdat1 = 32'h200;
    fetch(32'h03E00008, 32'h180, 32'h184);
    chk("jr_sig",   32'(jump_sig), 32'd2);
    chk("jr_tgt",   jump_jr, 32'h200);
    chk("jr_rsel1", 32'(rf_rsel1), 32'd31);
    idex_memread = 1'b1; idex_rt = 5'd31;
    #1;
    chk("jr_lu",      32'(load_use), 32'd1);
    chk("jr_lu_sig",  32'(jump_sig), 32'd0);
    idex_memread = 1'b0; idex_rt = 5'd0;

    if_instr = 32'h2008000A; if_pc = 32'h300; if_pp4 = 32'h304; if_valid = 1'b1;
    flush = 1'b1; mem_stall = 1'b1;
    tick();
    chk("fs_pc",    id_pc, 32'h180);
    chk("fs_valid", 32'(id_valid), 32'd1);
    chk("fs_funct", 32'(id_funct), 32'd8);
    mem_stall = 1'b0;
    tick();
    flush = 1'b0;
    chk("fl_valid", 32'(id_valid), 32'd0);
    chk("fl_funct", 32'(id_funct), 32'd0);
    chk("fl_pc",    id_pc, 32'h180);
    chk("fl_jump",  32'(jump_sig), 32'd0);

    // andi zero-extends, addi sign-extends
    fetch(32'h3108FFFF, 32'h200, 32'h204);
    chk("andi_imm", id_imm_ext, 32'h0000FFFF);
    fetch(32'h2008FFFF, 32'h204, 32'h208);
    chk("addi_neg", id_imm_ext, 32'hFFFFFFFF);
    fetch(32'hF8000000, 32'h208, 32'h20C);
    chk("unk_valid", 32'(id_valid), 32'd1);
    chk("unk_ctrl",  32'(id_ctrl), 32'd0);

    fetch(32'hFFFFFFFF, 32'h400, 32'h404);
    chk("halt_pre", 32'(halt), 32'd0);
    if_valid = 1'b0;
    tick();
    chk("halt_set", 32'(halt), 32'd1);
    fetch(32'h2008000A, 32'h500, 32'h504);
    chk("halt_hold",  32'(halt), 32'd1);
    chk("halt_pc",    id_pc, 32'h400);
    chk("halt_valid", 32'(id_valid), 32'd0);
    fetch(32'h2008000A, 32'h600, 32'h604);
    chk("halt_pc2", id_pc, 32'h400);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("halt_clr", 32'(halt), 32'd0);
    chk("halt_clr_pc", id_pc, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
